// File: rtl/kb_pkg.sv
// kb_pkg: register map, status/control bit positions, scan-code constants and filter states
package kb_pkg;
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;
  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_PERR = 3;
  localparam int CTL_IEN = 0;
  localparam int CTL_OVF_CLR = 2;
  localparam int CTL_PERR_CLR = 3;
  localparam int CTL_FLUSH = 7;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
  typedef enum logic [1:0] {F_IDLE, F_GOT_F0, F_DROP} filt_state_t;
  function automatic logic [3:0] sat4(input int unsigned c);
    return c > 15 ? 4'hF : c[3:0];
  endfunction
endpackage

// File: rtl/kb_sync_fifo.sv
// kb_sync_fifo: synchronous FIFO storage with pointers, occupancy count, push/pop/flush
module kb_sync_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          head,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_nx,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int PW = DEPTH_LOG2;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push_ok, pop_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign pop_ok = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push_ok = push & (~full | pop_ok);
  assign count_nx = flush ? '0 : count + CW'(push_ok) - CW'(pop_ok);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= flush ? '0 : rd_ptr + PW'(pop_ok);
      wr_ptr <= flush ? '0 : wr_ptr + PW'(push_ok);
      count <= count_nx;
    end
  always_ff @(posedge clk)
    if (push_ok & ~flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/kb_fifo_ctrl.sv
// kb_fifo_ctrl: PS/2 scan-code FIFO with Z180 DATA/STATUS register window and active-low INT
// Optional break-code filter enabled by defining KB_BREAK_FILTER_EN.
import kb_pkg::*;
module kb_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 3,
  parameter int IRQ_THRESH = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_perr,
  input  logic       SEL,
  input  logic       A0,
  input  logic       IOREQ,
  input  logic       R,
  input  logic       W,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe,
  output logic       INT
);
  logic rd_acc, wr_acc, rd_q, wr_q, a0_q;
  logic [7:0] d_q, head, status;
  logic pop, wr_commit, flush, keep, full, empty;
  logic ovf, perr, ien, ovf_nx, perr_nx, ien_nx, int_nx;
  logic [DEPTH_LOG2:0] count, count_nx;
  assign rd_acc = ~SEL & ~IOREQ & ~R;
  assign wr_acc = ~SEL & ~IOREQ & ~W;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      a0_q <= 1'b0;
      d_q <= '0;
      ovf <= 1'b0;
      perr <= 1'b0;
      ien <= 1'b0;
      INT <= 1'b1;
    end else begin
      rd_q <= rd_acc;
      wr_q <= wr_acc;
      if (rd_acc | wr_acc) a0_q <= A0;
      if (wr_acc) d_q <= D_in;
      ovf <= ovf_nx;
      perr <= perr_nx;
      ien <= ien_nx;
      INT <= ~int_nx;
    end
  // actions fire once, on the falling edge of the sampled access
  assign pop = rd_q & ~rd_acc & (a0_q == REG_DATA);
  assign wr_commit = wr_q & ~wr_acc & (a0_q == REG_STATUS);
  assign flush = wr_commit & d_q[CTL_FLUSH];
  always_comb begin
    ien_nx = wr_commit ? d_q[CTL_IEN] : ien;
    ovf_nx = (ovf & ~(wr_commit & d_q[CTL_OVF_CLR])) | (keep & full & ~pop & ~flush);
    perr_nx = (perr & ~(wr_commit & d_q[CTL_PERR_CLR])) | (rx_valid & rx_perr);
    int_nx = ien_nx & ((int'(count_nx) >= IRQ_THRESH) | ovf_nx);
  end
`ifdef KB_BREAK_FILTER_EN
  filt_state_t fs, fs_nx;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) fs <= F_IDLE;
    else fs <= fs_nx;
  always_comb begin
    fs_nx = (fs == F_DROP) ? F_IDLE : fs;
    keep = 1'b0;
    if (rx_valid) begin
      if (rx_perr) fs_nx = F_IDLE;
      else if (fs == F_GOT_F0) fs_nx = F_DROP;
      else begin
        fs_nx = (rx_data == SC_BREAK) ? F_GOT_F0 : F_IDLE;
        keep = (rx_data != SC_BREAK) | (rx_data == SC_EXT);
      end
    end
  end
`else
  assign keep = rx_valid & ~rx_perr;
`endif
  kb_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(8)) u_fifo (
    .clk(CLK),
    .rst_n(RST),
    .push(keep),
    .pop(pop),
    .flush(flush),
    .din(rx_data),
    .head(head),
    .count(count),
    .count_nx(count_nx),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    status = '0;
    status[7:4] = sat4(32'(count));
    status[ST_PERR] = perr;
    status[ST_OVF] = ovf;
    status[ST_FULL] = full;
    status[ST_NEMPTY] = ~empty;
  end
  assign D_oe = rd_acc;
  assign D_out = ~rd_acc ? 8'h00 : (A0 == REG_STATUS) ? status : (empty ? 8'h00 : head);
endmodule

// File: tb/tb_kb_fifo_ctrl.sv
// tb_kb_fifo_ctrl: directed plus randomized checks of kb_fifo_ctrl against a queue-based model
module tb_kb_fifo_ctrl;
  logic CLK = 0, RST = 0, rx_valid = 0, rx_perr = 0;
  logic SEL = 1, A0 = 0, IOREQ = 1, R = 1, W = 1;
  logic [7:0] rx_data = 0, D_in = 0, D_out;
  logic D_oe, INT;
  int checks = 0, failures = 0;
  logic [7:0] q[$];
  bit m_ovf = 0, m_perr = 0, m_ien = 0, m_brk = 0;
  logic [7:0] v;

  always #5 CLK = ~CLK;

  kb_fifo_ctrl dut (
    .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr),
    .SEL(SEL), .A0(A0), .IOREQ(IOREQ), .R(R), .W(W), .D_in(D_in),
    .D_out(D_out), .D_oe(D_oe), .INT(INT)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    int c = q.size();
    logic [3:0] cd = (c > 15) ? 4'hF : 4'(c);
    return {cd, m_perr, m_ovf, q.size() == 8, q.size() != 0};
  endfunction

  function automatic logic m_int();
    return !(m_ien && (q.size() >= 1 || m_ovf));
  endfunction

  function automatic void m_push(input logic [7:0] b, input logic pe);
    if (pe) begin
      m_perr = 1;
      m_brk = 0;
      return;
    end
`ifdef KB_BREAK_FILTER_EN
    if (m_brk) begin
      m_brk = 0;
      return;
    end
    if (b == 8'hF0) begin
      m_brk = 1;
      return;
    end
`endif
    if (q.size() == 8) m_ovf = 1;
    else q.push_back(b);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic pe);
    rx_valid = 1; rx_data = b; rx_perr = pe;
    tick();
    rx_valid = 0; rx_perr = 0; rx_data = 8'($urandom);
    m_push(b, pe);
  endtask

  task automatic rd(input logic a, input int n, output logic [7:0] val);
    A0 = a; SEL = 0; IOREQ = 0; R = 0;
    #2;
    chk("d_oe", {7'd0, D_oe}, 8'h01);
    val = D_out;
    repeat (n) tick();
    SEL = 1; IOREQ = 1; R = 1;
    tick();
  endtask

  task automatic rd_data(input string tag, input int n);
    rd(0, n, v);
    chk(tag, v, q.size() != 0 ? q[0] : 8'h00);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic rd_stat(input string tag);
    rd(1, 1, v);
    chk(tag, v, m_status());
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    A0 = a; D_in = d; SEL = 0; IOREQ = 0; W = 0;
    tick();
    SEL = 1; IOREQ = 1; W = 1; D_in = 8'($urandom);
    tick();
    if (a) begin
      m_ien = d[0];
      if (d[2]) m_ovf = 0;
      if (d[3]) m_perr = 0;
      if (d[7]) q.delete();
    end
  endtask

  task automatic push_pop(input logic [7:0] b);
    A0 = 0; SEL = 0; IOREQ = 0; R = 0;
    #2;
    chk("pp_head", D_out, q.size() != 0 ? q[0] : 8'h00);
    tick();
    SEL = 1; IOREQ = 1; R = 1;
    rx_valid = 1; rx_data = b; rx_perr = 0;
    tick();
    rx_valid = 0;
    if (q.size() != 0) void'(q.pop_front());
    m_push(b, 0);
  endtask

  task automatic chk_int(input string tag);
    tick();
    chk(tag, {7'd0, INT}, {7'd0, m_int()});
  endtask

  initial begin
    tick(); tick();
    chk("rst_doe", {7'd0, D_oe}, 8'h00);
    chk("rst_int", {7'd0, INT}, 8'h01);
    chk("rst_dout", D_out, 8'h00);
    RST = 1;
    tick();
    rd_stat("rst_status");
    // basic order and single pop on a held read
    push_byte(8'h1C, 0); push_byte(8'h32, 0);
    rd_data("rd_1c", 1); rd_data("rd_32", 1);
    rd_stat("empty_status");
    push_byte(8'hAA, 0); push_byte(8'hBB, 0);
    rd_data("held_rd", 5);
    rd_stat("held_status");
    rd_data("after_held", 1);
    // overflow
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 0);
    rd_stat("full_status");
    push_byte(8'h09, 0);
    rd_stat("ovf_status");
    for (int i = 0; i < 8; i++) rd_data("ovf_drain", 1);
    wr(1, 8'h04);
    rd_stat("ovf_clear");
    // full plus coincident push and pop
    for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i), 0);
    push_pop(8'h5A);
    rd_stat("pp_full_status");
    for (int i = 0; i < 8; i++) rd_data("pp_drain", 1);
    push_pop(8'h66);
    rd_stat("pp_empty_status");
    rd_data("pp_empty_rd", 1);
    // parity error
    push_byte(8'h55, 1);
    rd_stat("perr_status");
    wr(1, 8'h08);
    rd_stat("perr_clear");
    // interrupts and flush
    wr(1, 8'h01);
    push_byte(8'h42, 0);
    chk_int("int_low");
    rd_data("int_pop", 1);
    chk_int("int_high");
    push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 0);
    wr(0, 8'h80);
    rd_stat("a0_write_ignored");
    wr(1, 8'h80);
    rd_stat("flush_status");
    chk_int("flush_int");
    // break filter sequence
    push_byte(8'h1C, 0); push_byte(8'hF0, 0); push_byte(8'h1C, 0);
    push_byte(8'hE0, 0); push_byte(8'h75, 0);
    rd_stat("filt_status");
    while (q.size() != 0) rd_data("filt_drain", 1);
    rd_stat("filt_empty");
    // randomized mix
    for (int i = 0; i < 400; i++) begin
      int op = $urandom_range(0, 9);
      logic [7:0] d = 8'($urandom);
      if (op <= 3) push_byte(d, $urandom_range(0, 9) == 0);
      else if (op <= 5) rd_data("rnd_data", $urandom_range(1, 3));
      else if (op == 6) rd_stat("rnd_status");
      else if (op == 7) begin
        if ($urandom_range(0, 3) != 0) d[7] = 0;
        wr(1, d);
      end else if (op == 8) chk_int("rnd_int");
      else push_pop(d);
    end
    // reset during an access
    push_byte(8'h77, 0); push_byte(8'h88, 0);
    A0 = 0; SEL = 0; IOREQ = 0; R = 0;
    #2 RST = 0;
    #3 SEL = 1; IOREQ = 1; R = 1;
    q.delete(); m_ovf = 0; m_perr = 0; m_ien = 0; m_brk = 0;
    tick();
    chk("mid_rst_int", {7'd0, INT}, 8'h01);
    RST = 1;
    tick();
    rd_stat("mid_rst_status");
    push_byte(8'h99, 0);
    rd_data("post_rst_rd", 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
